// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, FSM encoding, requester
// count and the round-robin grant function.
package alu_pkg;

  localparam int NUM_REQ = 2;
  localparam int OP_W    = 4;
  localparam int INSTR_W = 32;

  localparam logic [OP_W-1:0] OP_AND     = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR      = 4'b0001;
  localparam logic [OP_W-1:0] OP_XOR     = 4'b0010;
  localparam logic [OP_W-1:0] OP_ADD     = 4'b0011;
  localparam logic [OP_W-1:0] OP_ADD_ALT = 4'b0100;
  localparam logic [OP_W-1:0] OP_SLT     = 4'b0101;
  localparam logic [OP_W-1:0] OP_SLTU    = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLL     = 4'b0111;
  localparam logic [OP_W-1:0] OP_SRL     = 4'b1000;
  localparam logic [OP_W-1:0] OP_SRA     = 4'b1001;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Non-width control fields captured alongside the operands.
  typedef struct packed {
    logic                id;
    logic                branch;
    logic [INSTR_W-1:0]  instruction;
    logic [OP_W-1:0]     opcode;
    logic                cin;
  } op_ctrl_t;

  function automatic logic [NUM_REQ-1:0] rr_grant(input logic [NUM_REQ-1:0] valid,
                                                  input logic               ptr);
    logic [NUM_REQ-1:0] g;
    case (valid)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = ptr ? 2'b10 : 2'b01;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, ALU and response signals of the ALU arbiter; slave is the arbiter
// side, master is the issue logic / ALU / consumer side.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
) ();
  import alu_pkg::*;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*WIDTH-1:0]   req_a;
  logic [NUM_REQ*WIDTH-1:0]   req_b;
  logic [NUM_REQ-1:0]         req_cin;
  logic [NUM_REQ*OP_W-1:0]    req_opcode;
  logic [NUM_REQ*INSTR_W-1:0] req_instruction;
  logic [NUM_REQ-1:0]         req_branch;

  logic [WIDTH-1:0]           alu_a;
  logic [WIDTH-1:0]           alu_b;
  logic                       alu_cin;
  logic [OP_W-1:0]            alu_opcode;
  logic [INSTR_W-1:0]         alu_instruction;
  logic                       alu_branch;
  logic [WIDTH-1:0]           alu_out;
  logic                       alu_branch_taken;

  logic                       rsp_valid;
  logic                       rsp_ready;
  logic                       rsp_id;
  logic [WIDTH-1:0]           rsp_out;
  logic                       rsp_branch_taken;

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_opcode, req_instruction, req_branch,
    input  alu_out, alu_branch_taken, rsp_ready,
    output req_ready, alu_a, alu_b, alu_cin, alu_opcode, alu_instruction, alu_branch,
    output rsp_valid, rsp_id, rsp_out, rsp_branch_taken
  );

  modport master (
    output req_valid, req_a, req_b, req_cin, req_opcode, req_instruction, req_branch,
    output alu_out, alu_branch_taken, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_cin, alu_opcode, alu_instruction, alu_branch,
    input  rsp_valid, rsp_id, rsp_out, rsp_branch_taken
  );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from valid and the
// priority pointer; the pointer moves past the winner on each accept.
module rr_arb2
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic               can_accept_i,
  output logic [NUM_REQ-1:0] req_ready_o,
  output logic               accept_o,
  output logic               accept_id_o
);

  logic               ptr_q;
  logic               ptr_d;
  logic [NUM_REQ-1:0] grant;

  assign grant       = rr_grant(req_valid_i, ptr_q);
  assign req_ready_o = grant & {NUM_REQ{can_accept_i}};
  // grant is a subset of valid, so any ready bit is an accept
  assign accept_o    = |req_ready_o;
  assign accept_id_o = req_ready_o[1];

  always_comb begin
    ptr_d = ptr_q;
    if (accept_o) ptr_d = ~accept_id_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: accepts a request,
// presents its registered operands for one cycle, then holds the tagged result.
//
// state | meaning
// IDLE  | nothing in flight, any granted request is accepted
// EXEC  | captured operands drive the ALU; result captured at the next edge
// RESP  | response held until rsp_ready; a new request may be accepted alongside
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             can_accept;
  logic             accept;
  logic             accept_id;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] b_d;
  op_ctrl_t         ctrl_q;
  op_ctrl_t         ctrl_d;

  logic [WIDTH-1:0] rsp_out_q;
  logic [WIDTH-1:0] rsp_out_d;
  logic             rsp_id_q;
  logic             rsp_id_d;
  logic             rsp_taken_q;
  logic             rsp_taken_d;

  // Gated by rst_n so req_ready stays low for the whole reset assertion.
  assign can_accept = rst_n & ((state_q == ST_IDLE) |
                               ((state_q == ST_RESP) & bus.rsp_ready));

  rr_arb2 u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (bus.req_valid),
    .can_accept_i (can_accept),
    .req_ready_o  (bus.req_ready),
    .accept_o     (accept),
    .accept_id_o  (accept_id)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_d = accept ? ST_EXEC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    ctrl_d = ctrl_q;
    if (accept) begin
      a_d    = accept_id ? bus.req_a[WIDTH +: WIDTH] : bus.req_a[0 +: WIDTH];
      b_d    = accept_id ? bus.req_b[WIDTH +: WIDTH] : bus.req_b[0 +: WIDTH];
      ctrl_d = '{
        id:          accept_id,
        branch:      bus.req_branch[accept_id],
        instruction: accept_id ? bus.req_instruction[INSTR_W +: INSTR_W]
                               : bus.req_instruction[0 +: INSTR_W],
        opcode:      accept_id ? bus.req_opcode[OP_W +: OP_W]
                               : bus.req_opcode[0 +: OP_W],
        cin:         bus.req_cin[accept_id]
      };
    end
  end

  always_comb begin
    rsp_out_d   = rsp_out_q;
    rsp_id_d    = rsp_id_q;
    rsp_taken_d = rsp_taken_q;
    if (state_q == ST_EXEC) begin
      rsp_out_d   = bus.alu_out;
      rsp_id_d    = ctrl_q.id;
      rsp_taken_d = bus.alu_branch_taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      rsp_out_q   <= '0;
      rsp_id_q    <= 1'b0;
      rsp_taken_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctrl_q      <= ctrl_d;
      rsp_out_q   <= rsp_out_d;
      rsp_id_q    <= rsp_id_d;
      rsp_taken_q <= rsp_taken_d;
    end
  end

  // Operand registers keep driving the ALU outside EXEC to avoid toggling it.
  assign bus.alu_a            = a_q;
  assign bus.alu_b            = b_q;
  assign bus.alu_cin          = ctrl_q.cin;
  assign bus.alu_opcode       = ctrl_q.opcode;
  assign bus.alu_instruction  = ctrl_q.instruction;
  assign bus.alu_branch       = ctrl_q.branch;

  assign bus.rsp_valid        = (state_q == ST_RESP);
  assign bus.rsp_id           = rsp_id_q;
  assign bus.rsp_out          = rsp_out_q;
  assign bus.rsp_branch_taken = rsp_taken_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, vector table, scoreboard of expected
// responses and hand sequences for backpressure, streaming and reset.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  typedef struct {
    int          id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        br;
    logic [31:0] instr;
    logic [31:0] exp_out;
    logic        exp_taken;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] out;
    logic        taken;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_arbiter_if #(.WIDTH(WIDTH)) bus ();
  alu_arbiter #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Behavioural single-cycle ALU; branch taken when the result is zero.
  logic [WIDTH-1:0] alu_res;
  always_comb begin
    alu_res = bus.alu_b;
    case (bus.alu_opcode)
      OP_AND:             alu_res = bus.alu_a & bus.alu_b;
      OP_OR:              alu_res = bus.alu_a | bus.alu_b;
      OP_XOR:             alu_res = bus.alu_a ^ bus.alu_b;
      OP_ADD, OP_ADD_ALT: alu_res = bus.alu_a + bus.alu_b + {31'b0, bus.alu_cin};
      OP_SLT:             alu_res = {31'b0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      OP_SLTU:            alu_res = {31'b0, bus.alu_a < bus.alu_b};
      OP_SLL:             alu_res = bus.alu_a << bus.alu_b[4:0];
      OP_SRL:             alu_res = bus.alu_a >> bus.alu_b[4:0];
      OP_SRA:             alu_res = $unsigned($signed(bus.alu_a) >>> bus.alu_b[4:0]);
      default:            alu_res = bus.alu_b;
    endcase
  end
  assign bus.alu_out          = alu_res;
  assign bus.alu_branch_taken = bus.alu_branch & (alu_res == '0);

  vec_t cur [2];
  vec_t last_acc;
  vec_t pendq0 [$];
  vec_t pendq1 [$];
  rsp_t sb [$];
  int   acc_log [$];
  int   rsp_cyc [$];
  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input int id, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic cin, input logic br,
                               input logic [31:0] instr, input logic [31:0] exp_out,
                               input logic exp_taken);
    vec_t v;
    v.id = id; v.op = op; v.a = a; v.b = b; v.cin = cin; v.br = br;
    v.instr = instr; v.exp_out = exp_out; v.exp_taken = exp_taken;
    return v;
  endfunction

  task automatic load(input int id, input vec_t v);
    cur[id] = v;
    bus.req_a[id*WIDTH +: WIDTH]  = v.a;
    bus.req_b[id*WIDTH +: WIDTH]  = v.b;
    bus.req_cin[id]               = v.cin;
    bus.req_opcode[id*4 +: 4]     = v.op;
    bus.req_instruction[id*32 +: 32] = v.instr;
    bus.req_branch[id]            = v.br;
    bus.req_valid[id]             = 1'b1;
  endtask

  // Monitor: ALU inputs must equal the last accepted payload, ready is one-hot
  // and within valid, responses are popped from the scoreboard in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      last_acc = mkv(0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    end else begin
      chk("alu_a_hold", 64'(bus.alu_a), 64'(last_acc.a));
      chk("alu_b_hold", 64'(bus.alu_b), 64'(last_acc.b));
      chk("alu_ctrl_hold", 64'({bus.alu_cin, bus.alu_opcode, bus.alu_branch, bus.alu_instruction}),
          64'({last_acc.cin, last_acc.op, last_acc.br, last_acc.instr}));
      checks++;
      if ((bus.req_ready & ~bus.req_valid) != 2'b00 || bus.req_ready == 2'b11) begin
        errors++;
        $display("FAIL req_ready_onehot: ready %b valid %b", bus.req_ready, bus.req_valid);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        rsp_t e;
        rsp_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: id %0d out %0h with nothing outstanding", bus.rsp_id, bus.rsp_out);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
          chk("rsp_out", 64'(bus.rsp_out), 64'(e.out));
          chk("rsp_taken", 64'(bus.rsp_branch_taken), 64'(e.taken));
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          rsp_t n;
          n.id = i[0]; n.out = cur[i].exp_out; n.taken = cur[i].exp_taken;
          sb.push_back(n);
          last_acc = cur[i];
          acc_log.push_back(i);
        end
      end
    end
  end

  // Feed queued vectors, keeping a requester's valid high until accepted.
  task automatic run(input int budget);
    logic [1:0] acc;
    int n;
    acc = 2'b00;
    n = 0;
    while (n < budget) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) if (acc[i]) bus.req_valid[i] = 1'b0;
      if (!bus.req_valid[0] && pendq0.size() > 0) load(0, pendq0.pop_front());
      if (!bus.req_valid[1] && pendq1.size() > 0) load(1, pendq1.pop_front());
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      n++;
      if (acc == 2'b00 && bus.req_valid == 2'b00 && pendq0.size() == 0 &&
          pendq1.size() == 0 && sb.size() == 0 && !bus.rsp_valid) break;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL run_timeout: %0d cycles, %0d responses outstanding", n, sb.size());
      pendq0.delete(); pendq1.delete();
      bus.req_valid = 2'b00;
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({name, "_rsp"}, 64'({bus.rsp_id, bus.rsp_branch_taken, bus.rsp_out}), 64'd0);
    chk({name, "_alu_ab"}, {bus.alu_a, bus.alu_b}, 64'd0);
    chk({name, "_alu_ctrl"}, 64'({bus.alu_cin, bus.alu_opcode, bus.alu_branch, bus.alu_instruction}), 64'd0);
    chk({name, "_req_ready"}, 64'(bus.req_ready), 64'd0);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    vec_t v;
    int k;
    bus.req_valid = 2'b00; bus.req_a = '0; bus.req_b = '0; bus.req_cin = '0;
    bus.req_opcode = '0; bus.req_instruction = '0; bus.req_branch = '0;
    bus.rsp_ready = 1'b1;

    tbl[0]  = mkv(0, OP_ADD,     32'd5,        32'd7,        1'b0, 1'b0, 32'h1000_0000, 32'd12,       1'b0);
    tbl[1]  = mkv(1, OP_ADD_ALT, 32'hFFFF_FFFF, 32'h0,       1'b1, 1'b0, 32'h1000_0001, 32'h0,        1'b0);
    tbl[2]  = mkv(0, OP_XOR,     32'hF0F0_F0F0, 32'hFFFF_0000, 1'b0, 1'b0, 32'h1000_0002, 32'h0F0F_F0F0, 1'b0);
    tbl[3]  = mkv(1, OP_OR,      32'h1,        32'h2,        1'b0, 1'b0, 32'h1000_0003, 32'h3,        1'b0);
    tbl[4]  = mkv(0, OP_SLT,     32'hFFFF_FFFE, 32'h1,       1'b0, 1'b0, 32'h1000_0004, 32'h1,        1'b0);
    tbl[5]  = mkv(1, OP_SLTU,    32'hFFFF_FFFE, 32'h1,       1'b0, 1'b0, 32'h1000_0005, 32'h0,        1'b0);
    tbl[6]  = mkv(0, OP_SLL,     32'h1,        32'd4,        1'b0, 1'b0, 32'h1000_0006, 32'h10,       1'b0);
    tbl[7]  = mkv(1, OP_SRL,     32'h8000_0000, 32'd31,      1'b0, 1'b0, 32'h1000_0007, 32'h1,        1'b0);
    tbl[8]  = mkv(0, OP_SRA,     32'h8000_0000, 32'd4,       1'b0, 1'b0, 32'h1000_0008, 32'hF800_0000, 1'b0);
    tbl[9]  = mkv(1, 4'b1111,    32'h1234,     32'hDEAD_BEEF, 1'b1, 1'b0, 32'h1000_0009, 32'hDEAD_BEEF, 1'b0);
    tbl[10] = mkv(0, 4'b1010,    32'h1,        32'h1234_5678, 1'b0, 1'b0, 32'h1000_000A, 32'h1234_5678, 1'b0);
    tbl[11] = mkv(1, OP_XOR,     32'h55,       32'h55,       1'b0, 1'b1, 32'hC000_0063, 32'h0,        1'b1);
    tbl[12] = mkv(0, OP_AND,     32'hFF,       32'h0F,       1'b0, 1'b1, 32'hC000_0163, 32'h0F,       1'b0);

    // Reset: outputs zero and no ready even with both requests valid.
    load(0, tbl[3]); load(1, tbl[4]);
    #12;
    chk_all_zero("reset");
    bus.req_valid = 2'b00;
    @(posedge clk); #1 rst_n = 1'b1;

    // Single request: ready in the same cycle, response two edges after accept.
    @(posedge clk); #1 load(0, tbl[0]);
    @(negedge clk);  chk("single_ready", 64'(bus.req_ready), 64'b01);
    @(posedge clk); #1 bus.req_valid[0] = 1'b0;
    @(negedge clk);  chk("single_exec_no_rsp", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    chk("single_rsp", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_out}), {31'd0, 1'b1, 1'b0, 32'd12});

    // Table vectors, one at a time.
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].id == 0) pendq0.push_back(tbl[i]);
      else                pendq1.push_back(tbl[i]);
      run(40);
    end

    // Contention with the pointer back at 0: grants must alternate 0,1,0,1,0,1.
    reset_pulse();
    acc_log.delete();
    pendq0.push_back(tbl[2]);
    pendq0.push_back(mkv(0, OP_AND, 32'hF0,  32'h3C, 1'b0, 1'b0, 32'h2000_0000, 32'h30, 1'b0));
    pendq0.push_back(mkv(0, OP_SLL, 32'h3,   32'h2,  1'b0, 1'b0, 32'h2000_0001, 32'hC,  1'b0));
    pendq1.push_back(tbl[3]);
    pendq1.push_back(mkv(1, OP_SRL, 32'h100, 32'h4,  1'b0, 1'b0, 32'h2000_0002, 32'h10, 1'b0));
    pendq1.push_back(mkv(1, OP_ADD, 32'h10,  32'h20, 1'b1, 1'b0, 32'h2000_0003, 32'h31, 1'b0));
    run(100);
    chk("contend_count", 64'(acc_log.size()), 64'd6);
    for (int i = 0; i < acc_log.size(); i++) chk("contend_order", 64'(acc_log[i]), 64'(i % 2));

    // Streaming: requester 1 always valid, one response every 2 cycles.
    rsp_cyc.delete();
    for (k = 1; k <= 4; k++)
      pendq1.push_back(mkv(1, OP_ADD, 32'(100*k), 32'(k), k[0], 1'b0, 32'(32'h3000_0000 + k),
                           32'(101*k + (k % 2)), 1'b0));
    run(100);
    chk("stream_count", 64'(rsp_cyc.size()), 64'd4);
    for (int i = 1; i < rsp_cyc.size(); i++)
      chk("stream_spacing", 64'(rsp_cyc[i] - rsp_cyc[i-1]), 64'd2);

    // Backpressure: response held 5 cycles, ready stays low with req1 pending.
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1 load(0, tbl[12]);
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.req_ready[0] && k < 10);
    chk("bp_accept", 64'(bus.req_ready), 64'b01);
    @(posedge clk); #1 bus.req_valid[0] = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.rsp_valid && k < 10);
    chk("bp_rsp_seen", 64'(bus.rsp_valid), 64'd1);
    @(posedge clk); #1 load(1, tbl[7]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", 64'({bus.rsp_valid, bus.rsp_id, bus.req_ready, bus.rsp_out}),
          {29'd0, 1'b1, 1'b0, 2'b00, 32'h0F});
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(negedge clk);  chk("bp_release_accept", 64'(bus.req_ready), 64'b10);
    @(posedge clk); #1 bus.req_valid[1] = 1'b0;
    run(40);

    // Reset during EXEC: everything clears at once and no response follows.
    v = mkv(0, OP_OR, 32'hA5A5_0000, 32'h0000_5A5A, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hA5A5_5A5A, 1'b0);
    @(posedge clk); #1 load(0, v);
    @(negedge clk);  chk("midrst_accept", 64'(bus.req_ready), 64'b01);
    @(posedge clk); #2;
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    #1 chk_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
